// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detectors: size limits, the step
// action type and the elaboration-time helpers that build the KMP transition table.
package seq_det_pkg;

  localparam int MAX_PATTERN_LEN = 32;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_CLEAR
  } step_act_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 40; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Longest pattern prefix that is a suffix of (prefix_k, b).
  // pattern[len-1] is the first bit of the pattern.
  function automatic int next_state(input logic [MAX_PATTERN_LEN-1:0] pattern,
                                    input int len, input int k, input logic b);
    int   result;
    int   total;
    int   pos;
    logic ok;
    logic sbit;
    result = 0;
    total  = k + 1;
    for (int j = 1; j <= MAX_PATTERN_LEN; j++) begin
      if (j <= len && j <= total) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PATTERN_LEN; i++) begin
          if (i < j) begin
            pos  = total - j + i;
            sbit = (pos < k) ? pattern[len-1-pos] : b;
            if (sbit != pattern[len-1-i]) ok = 1'b0;
          end
        end
        if (ok) result = j;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Stream-in / status-out bundle shared by the serial pattern detectors.
interface seq_det_if #(
  parameter int CNT_W  = 8,
  parameter int PROG_W = 2
);
  logic              clear;
  logic              in_valid;
  logic              in_bit;
  logic              match;
  logic [CNT_W-1:0]  match_count;
  logic              count_sat;
  logic [PROG_W-1:0] progress;

  modport master (
    output clear, in_valid, in_bit,
    input  match, match_count, count_sat, progress
  );

  modport slave (
    input  clear, in_valid, in_bit,
    output match, match_count, count_sat, progress
  );
endinterface

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all ones.
module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = &count;

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Moore serial pattern detector: KMP state register with a transition table
// built at elaboration, plus a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b101,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input logic     clk,
  input logic     reset,
  seq_det_if.slave bus
);

  localparam int PW  = clog2(PATTERN_LEN + 1);
  localparam int TBL = 2 ** PW;
  localparam logic [PW-1:0] FINAL = PW'(PATTERN_LEN);
  localparam logic [MAX_PATTERN_LEN-1:0] PAT_EXT = MAX_PATTERN_LEN'(PATTERN);

  if (PATTERN_LEN < 1 || PATTERN_LEN > MAX_PATTERN_LEN || CNT_W < 1) begin : g_bad_param
    $error("seq_pattern_detector: illegal PATTERN_LEN=%0d or CNT_W=%0d", PATTERN_LEN, CNT_W);
  end

  logic [PW-1:0] next_on0 [TBL];
  logic [PW-1:0] next_on1 [TBL];

  // Without overlap a completed match restarts the search as if from state 0.
  for (genvar k = 0; k < TBL; k++) begin : g_tbl
    localparam int FROM = (!OVERLAP && k == PATTERN_LEN) ? 0 : k;
    localparam int N0   = (k <= PATTERN_LEN) ? next_state(PAT_EXT, PATTERN_LEN, FROM, 1'b0) : 0;
    localparam int N1   = (k <= PATTERN_LEN) ? next_state(PAT_EXT, PATTERN_LEN, FROM, 1'b1) : 0;
    assign next_on0[k] = PW'(N0);
    assign next_on1[k] = PW'(N1);
  end

  logic [PW-1:0] state_q;
  logic [PW-1:0] state_d;
  logic          inc;
  step_act_e     act;

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d = state_q;
    inc     = 1'b0;
    if (bus.clear)         act = ACT_CLEAR;
    else if (bus.in_valid) act = ACT_STEP;
    else                   act = ACT_HOLD;
    unique case (act)
      ACT_CLEAR: state_d = '0;
      ACT_STEP: begin
        state_d = bus.in_bit ? next_on1[state_q] : next_on0[state_q];
        inc     = (state_d == FINAL);
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  seq_det_sat_counter #(.CNT_W(CNT_W)) u_count (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .clr   (bus.clear),
    .count (bus.match_count),
    .sat   (bus.count_sat)
  );

  assign bus.match    = (state_q == FINAL);
  assign bus.progress = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Drives five detector configurations with one shared stream and compares each
// against a history-based prefix model every cycle, plus literal expectations.
module tb_seq_pattern_detector;
  import seq_det_pkg::*;

  localparam int NDUT = 5;
  localparam int          NS   [NDUT] = '{3, 3, 4, 3, 1};
  localparam logic [31:0] PATS [NDUT] = '{32'b101, 32'b101, 32'b1101, 32'b101, 32'b1};
  localparam bit          OVS  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam int          CWS  [NDUT] = '{8, 8, 8, 2, 8};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;

  logic [31:0] prog_a  [NDUT];
  logic [31:0] cnt_a   [NDUT];
  logic        match_a [NDUT];
  logic        sat_a   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int N  = NS[g];
    localparam int PW = clog2(N + 1);
    localparam logic [N-1:0] PAT = PATS[g][N-1:0];

    seq_det_if #(.CNT_W(CWS[g]), .PROG_W(PW)) bus ();

    assign bus.clear    = clear;
    assign bus.in_valid = in_valid;
    assign bus.in_bit   = in_bit;

    seq_pattern_detector #(
      .PATTERN_LEN (N),
      .PATTERN     (PAT),
      .OVERLAP     (OVS[g]),
      .CNT_W       (CWS[g])
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign prog_a[g]  = 32'(bus.progress);
    assign cnt_a[g]   = 32'(bus.match_count);
    assign match_a[g] = bus.match;
    assign sat_a[g]   = bus.count_sat;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: keep the accepted bits since the last restart and search
  // directly for the longest pattern prefix ending at the newest bit.
  logic [63:0] hist   [NDUT];
  int          hlen   [NDUT];
  int          mstate [NDUT];
  longint      mcount [NDUT];
  bit          armed = 1'b0;

  function automatic int longest_prefix(input logic [63:0] h, input int hl,
                                        input logic [31:0] p, input int n);
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j <= 32; j++) begin
      if (j <= n && j <= hl) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) if (h[j-1-i] != p[n-1-i]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (reset || clear) begin
        hist[d] = '0; hlen[d] = 0; mstate[d] = 0; mcount[d] = 0;
      end else if (in_valid) begin
        if (!OVS[d] && mstate[d] == NS[d]) begin
          hist[d] = '0; hlen[d] = 0;
        end
        hist[d]   = {hist[d][62:0], in_bit};
        hlen[d]   = (hlen[d] < 64) ? hlen[d] + 1 : 64;
        mstate[d] = longest_prefix(hist[d], hlen[d], PATS[d], NS[d]);
        if (mstate[d] == NS[d] && mcount[d] < (longint'(1) << CWS[d]) - 1) mcount[d]++;
      end
    end
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("d%0d_progress", d), prog_a[d], 32'(mstate[d]));
        check($sformatf("d%0d_match", d), 32'(match_a[d]), 32'(mstate[d] == NS[d]));
        check($sformatf("d%0d_count", d), cnt_a[d], 32'(mcount[d]));
        check($sformatf("d%0d_sat", d), 32'(sat_a[d]),
              32'(mcount[d] == (longint'(1) << CWS[d]) - 1));
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic c, input logic r);
    in_valid = v; in_bit = b; clear = c; reset = r;
    @(posedge clk);
    #1;
  endtask

  int bits_a  [5] = '{1, 0, 1, 0, 1};
  int p0_a    [5] = '{1, 2, 3, 2, 3};
  int p1_a    [5] = '{1, 2, 3, 0, 1};
  int bits_c  [5] = '{1, 1, 1, 0, 1};
  int p2_c    [5] = '{1, 2, 2, 3, 4};
  int gap_v   [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
  int gap_b   [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
  int gap_p   [9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_progress_d%0d", d), prog_a[d], 32'd0);
      check($sformatf("rst_count_d%0d", d), cnt_a[d], 32'd0);
      check($sformatf("rst_match_d%0d", d), 32'(match_a[d]), 32'd0);
      check($sformatf("rst_sat_d%0d", d), 32'(sat_a[d]), 32'd0);
    end

    // Overlap vs non-overlap on 1,0,1,0,1; N=1 follows each bit.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits_a[i][0], 1'b0, 1'b0);
      check("ovl_progress", prog_a[0], 32'(p0_a[i]));
      check("novl_progress", prog_a[1], 32'(p1_a[i]));
      check("ovl_match", 32'(match_a[0]), 32'(p0_a[i] == 3));
      check("novl_match", 32'(match_a[1]), 32'(p1_a[i] == 3));
      check("n1_match", 32'(match_a[4]), 32'(bits_a[i]));
    end
    check("ovl_count", cnt_a[0], 32'd2);
    check("novl_count", cnt_a[1], 32'd1);

    // Four-bit pattern 1101 with KMP fallback on 1,1,1,0,1.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits_c[i][0], 1'b0, 1'b0);
      check("p1101_progress", prog_a[2], 32'(p2_c[i]));
    end
    check("p1101_count", cnt_a[2], 32'd1);

    // Gaps in in_valid hold state and match.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(gap_v[i][0], gap_b[i][0], 1'b0, 1'b0);
      check("gap_progress", prog_a[0], 32'(gap_p[i]));
      check("gap_match", 32'(match_a[0]), 32'(i >= 6));
    end

    // Saturation: long alternating stream.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, ~i[0], 1'b0, 1'b0);
    check("cw2_count", cnt_a[3], 32'd3);
    check("cw2_sat", 32'(sat_a[3]), 32'd1);
    check("cw8_count_5", cnt_a[0], 32'd5);
    for (int i = 11; i < 600; i++) step(1'b1, ~i[0], 1'b0, 1'b0);
    check("cw8_count_sat", cnt_a[0], 32'd255);
    check("cw8_sat", 32'(sat_a[0]), 32'd1);
    check("novl_count_long", cnt_a[1], 32'd150);
    check("n1_count_sat", cnt_a[4], 32'd255);

    // Clear mid-pattern drops the bit presented with it.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_progress", prog_a[0], 32'd0);
    check("clr_count", cnt_a[0], 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_progress_after", prog_a[0], 32'd1);
    check("clr_no_match", 32'(match_a[0]), 32'd0);

    // Reset mid-pattern, with clear also high: reset wins, everything zero.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", cnt_a[0], 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("mid_rst_progress", prog_a[0], 32'd0);
    check("mid_rst_match", 32'(match_a[0]), 32'd0);
    check("mid_rst_count", cnt_a[0], 32'd0);
    check("mid_rst_sat", 32'(sat_a[3]), 32'd0);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      step(($urandom_range(0, 3) != 0), 1'($urandom), (r < 3), (r == 999));
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
